// File: rtl/nrzi_frame_decoder.sv
// NRZI line decoder with SYNC-delimited framing and a single-entry output register.
// Payload bytes are assembled MSB-first and handed off through a valid/ready handshake.
module nrzi_frame_decoder #(
  parameter logic [7:0] SYNC      = 8'h7E,
  parameter int         FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_line_in,
  input  logic       i_bit_en,
  input  logic       i_clr,
  input  logic       i_data_ready,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  output logic       o_sync_found,
  output logic       o_frame_done,
  output logic       o_overflow,
  output logic       o_in_frame
);

  // state  | meaning
  // S_HUNT | sliding window searched for SYNC
  // S_DATA | assembling payload bytes of the current frame
  typedef enum logic {S_HUNT = 1'b0, S_DATA = 1'b1} state_t;

  localparam logic [3:0] LP_FRAME_LEN = 4'(FRAME_LEN);

  state_t     r_state;
  logic       r_line_prev;
  logic [7:0] r_window;
  logic [7:0] r_asm;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_byte_cnt;
  logic [7:0] r_data_out;
  logic       r_data_valid;
  logic       r_sync_found;
  logic       r_frame_done;
  logic       r_overflow;

  state_t     w_state_nxt;
  logic [7:0] w_window_nxt;
  logic [7:0] w_asm_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] w_byte_cnt_nxt;
  logic [3:0] w_byte_inc;
  logic       w_bit;
  logic       w_sync_hit;
  logic       w_byte_load;
  logic       w_last_byte;
  logic       w_consume;

  assign w_bit     = i_line_in ^ r_line_prev;
  assign w_consume = r_data_valid & i_data_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_window_nxt   = r_window;
    w_asm_nxt      = r_asm;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_byte_inc     = r_byte_cnt + 4'd1;
    w_sync_hit     = 1'b0;
    w_byte_load    = 1'b0;
    w_last_byte    = 1'b0;
    if (i_clr) begin
      w_state_nxt    = S_HUNT;
      w_window_nxt   = 8'h00;
      w_asm_nxt      = 8'h00;
      w_bit_cnt_nxt  = 3'd0;
      w_byte_cnt_nxt = 4'd0;
    end else if (i_bit_en) begin
      case (r_state)
        S_HUNT: begin
          w_window_nxt = {r_window[6:0], w_bit};
          if (w_window_nxt == SYNC) begin
            w_state_nxt    = S_DATA;
            w_sync_hit     = 1'b1;
            w_bit_cnt_nxt  = 3'd0;
            w_byte_cnt_nxt = 4'd0;
          end
        end
        S_DATA: begin
          // SYNC-looking payload is deliberately not searched for here
          w_asm_nxt     = {r_asm[6:0], w_bit};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_byte_load    = 1'b1;
            w_byte_cnt_nxt = w_byte_inc;
            if (w_byte_inc == LP_FRAME_LEN) begin
              w_last_byte    = 1'b1;
              w_state_nxt    = S_HUNT;
              w_window_nxt   = 8'h00;
              w_byte_cnt_nxt = 4'd0;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_line_prev <= 1'b0;
      r_window    <= 8'h00;
      r_asm       <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 4'd0;
    end else begin
      // line history must track the line even through clr, or the next bit decodes wrong
      if (i_bit_en) r_line_prev <= i_line_in;
      r_state    <= w_state_nxt;
      r_window   <= w_window_nxt;
      r_asm      <= w_asm_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_sync_found <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sync_found <= w_sync_hit;
      r_frame_done <= w_last_byte;
      if (i_clr) begin
        r_data_valid <= 1'b0;
        r_overflow   <= 1'b0;
      end else if (w_byte_load) begin
        if (!r_data_valid || i_data_ready) begin
          r_data_out   <= w_asm_nxt;
          r_data_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_consume) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_sync_found = r_sync_found;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_in_frame   = (r_state == S_DATA);

endmodule

// File: doc/nrzi_frame_decoder.md
NRZI_FRAME_DECODER -- requirements
Module: nrzi_frame_decoder

Interface
REQ-001 Parameter: SYNC, default 8'h7E, frame-start pattern in the decoded bit stream.
REQ-002 Parameter: FRAME_LEN, default 4, payload bytes per frame (1..15).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 line_in  input  1  NRZI line level, driven by a toggle-on-1 encoder whose reset level is 0; synchronous to clk.
REQ-006 bit_en  input  1  one-cycle strobe marking a valid line_in sample.
REQ-007 clr  input  1  synchronous soft clear.
REQ-008 data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-009 data_out  output  8  decoded payload byte, MSB received first.
REQ-010 data_valid  output  1  data_out holds an unconsumed byte.
REQ-011 sync_found  output  1  one-cycle pulse on SYNC detection.
REQ-012 frame_done  output  1  one-cycle pulse when the last payload byte of a frame is loaded.
REQ-013 overflow  output  1  sticky flag: a completed byte was dropped.
REQ-014 in_frame  output  1  high while the FSM is in DATA.

Function
REQ-015 On each bit_en, line_prev SHALL sample line_in; decoded bit d = line_in XOR line_prev (value before update).
REQ-016 line_prev SHALL update on every bit_en regardless of FSM state or clr.
REQ-017 Without bit_en, no decode state (window, counters, FSM) SHALL change.
REQ-018 FSM SHALL have two states: HUNT and DATA. in_frame = (state == DATA).
REQ-019 HUNT: each d shifts into the LSB of an 8-bit window, left shift; when the updated window equals SYNC, go to DATA, clear bit and byte counters, and pulse sync_found in the next cycle.
REQ-020 DATA: each d shifts into an 8-bit assembly register, left shift; 3-bit bit counter increments and wraps from 7 to 0.
REQ-021 On the 8th bit, the assembled byte SHALL be offered to the output register, and the 4-bit byte counter SHALL increment.
REQ-022 When the byte counter reaches FRAME_LEN, frame_done SHALL pulse, the FSM SHALL return to HUNT, and the window SHALL clear to 8'h00.
REQ-023 SYNC patterns inside DATA SHALL be treated as payload.
REQ-024 Latency: data_valid and data_out update in the cycle after the bit_en carrying the 8th bit.
REQ-025 Handshake: byte consumed on a clock edge where data_valid && data_ready; data_valid then falls unless a new byte loads on the same edge.
REQ-026 data_out SHALL be stable while data_valid is high and not consumed.
REQ-027 New byte with output register empty, or consumed on the same edge: load it, data_valid = 1, no overflow.
REQ-028 New byte with data_valid = 1 and data_ready = 0: drop the new byte, keep the old data_out, set overflow.
REQ-029 overflow SHALL stay set until clr or reset.
REQ-030 clr: on the next edge, go to HUNT and clear window, assembly register, bit and byte counters, data_valid, and overflow; clr overrides a coincident bit_en (except REQ-016).

Reset
REQ-031 rst_n low: state = HUNT, line_prev = 0, window = 0, counters = 0, data_out = 8'h00, data_valid = 0, sync_found = 0, frame_done = 0, overflow = 0, in_frame = 0.
REQ-032 Reset mid-frame SHALL abandon the frame; no partial byte is ever presented.

Verification
REQ-033 Sync: line bits 0,1,0,1,0,1,0,0 (decodes to 0x7E) -> sync_found pulses once, in_frame = 1.
REQ-034 Payload: after sync, bytes A5,3C,FF,00 encoded, data_ready = 1 -> data_out shows A5,3C,FF,00, each valid for 1 cycle; frame_done pulses with 00; then in_frame = 0.
REQ-035 Backpressure: data_ready = 0 across two payload bytes -> data_out = A5 held, overflow = 1; after data_ready = 1, one consume, then data_valid = 0.
REQ-036 Same-edge consume: byte completes on the edge where A5 is accepted -> data_out = 3C, data_valid stays 1, overflow = 0.
REQ-037 Payload 7E inside a frame -> delivered as data; no sync_found pulse.
REQ-038 clr or rst_n asserted after 4 data bits -> HUNT, data_valid = 0, overflow = 0; the next SYNC plus 4 bytes decodes correctly.
